// File: rtl/ifetch_pkg.sv
// Shared types and constants for the V850 sequential instruction fetcher.
package ifetch_pkg;

  localparam int unsigned PC_W_DEF = 25;
  localparam int unsigned MEM_W    = 64;
  localparam int unsigned INST_W   = 48;
  localparam int unsigned HW_W     = 16;

  localparam logic [1:0] OP_LONG32_PREFIX = 2'b11;
  localparam logic [5:0] OP_MOV32         = 6'b110001;

  typedef enum logic {
    ST_WAIT,
    ST_CAPTURE
  } fetch_state_e;

  // Instruction length in bytes
  typedef enum logic [2:0] {
    LEN_16 = 3'd2,
    LEN_32 = 3'd4,
    LEN_48 = 3'd6
  } inst_len_e;

  // Memory window: hw0 is the halfword at the fetch address
  typedef struct packed {
    logic [HW_W-1:0] hw0;
    logic [HW_W-1:0] hw1;
    logic [HW_W-1:0] hw2;
    logic [HW_W-1:0] hw3;
  } mem_win_t;

  // Left-aligned instruction payload
  typedef struct packed {
    logic [HW_W-1:0] hw0;
    logic [HW_W-1:0] hw1;
    logic [HW_W-1:0] hw2;
  } inst_t;

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational length decode of the first halfword into byte length and halfword mask.
// The 48-bit MOV imm32 form is recognised only when IFETCH_LONG_INST_EN is defined.
module ifetch_len_decode
  import ifetch_pkg::*;
(
  input  logic [15:0] hw0,
  output logic [2:0]  len_c,
  output logic [2:0]  hw_mask_c
);

  logic unused_bits;
  assign unused_bits = ^{hw0[15:11], hw0[8:0]};

  // hw_mask_c bit 2 keeps hw0, bit 1 keeps hw1, bit 0 keeps hw2
  always_comb begin
    len_c     = 3'(LEN_16);
    hw_mask_c = 3'b100;
    if (hw0[10:9] == OP_LONG32_PREFIX) begin
      len_c     = 3'(LEN_32);
      hw_mask_c = 3'b110;
    end
`ifdef IFETCH_LONG_INST_EN
    if ((hw0[10:5] == OP_MOV32) && (hw0[4:0] == 5'b00000)) begin
      len_c     = 3'(LEN_48);
      hw_mask_c = 3'b111;
    end
`endif
  end

endmodule

// File: rtl/ifetcher.sv
// Sequential V850 instruction fetcher: wait/capture FSM, PC register and registered outputs.
// Optional 48-bit MOV imm32 fetch is enabled by defining IFETCH_LONG_INST_EN.
module ifetcher
  import ifetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_load_i,
  input  logic [PC_W-1:0]   PC_i,
  input  logic [MEM_W-1:0]  mem_i,
  output logic [INST_W-1:0] instruction_o,
  output logic              inst_valid_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic [PC_W-1:0]   PC_o
);

  localparam int unsigned      CNT_W       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(MEM_LAT - 1);
  localparam logic [PC_W-1:0]  RESET_PC_AL = {RESET_PC[PC_W-1:1], 1'b0};

  fetch_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  mem_win_t         win;
  inst_t            inst_c;
  logic [2:0]       len_c;
  logic [2:0]       hw_mask_c;
  logic             capture_c;
  logic [PC_W-1:0]  pc_next_c;
  logic [PC_W-1:0]  pc_load_c;
  logic             unused_in;

  assign win       = mem_win_t'(mem_i);
  assign unused_in = ^{win.hw3, PC_i[0]};

  ifetch_len_decode u_len_decode (
    .hw0       (win.hw0),
    .len_c     (len_c),
    .hw_mask_c (hw_mask_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a redirect always restarts the wait for the new address
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (PC_load_i) begin
      state_nxt = ST_WAIT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state_nxt = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode: capture strobe, masked instruction and next PC
  always_comb begin
    capture_c  = (state == ST_CAPTURE) && !PC_load_i;
    inst_c     = '0;
    inst_c.hw0 = win.hw0 & {HW_W{hw_mask_c[2]}};
    inst_c.hw1 = win.hw1 & {HW_W{hw_mask_c[1]}};
    inst_c.hw2 = win.hw2 & {HW_W{hw_mask_c[0]}};
    pc_next_c  = PC_o + PC_W'(len_c);
    pc_load_c  = {PC_i[PC_W-1:1], 1'b0};
  end

  // PC and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_o          <= RESET_PC_AL;
      inst_pc_o     <= RESET_PC_AL;
      instruction_o <= '0;
      inst_valid_o  <= 1'b0;
    end else begin
      inst_valid_o <= capture_c;
      if (PC_load_i) begin
        PC_o <= pc_load_c;
      end else if (capture_c) begin
        PC_o          <= pc_next_c;
        inst_pc_o     <= PC_o;
        instruction_o <= inst_c;
      end
    end
  end

endmodule

// File: tb/tb_ifetcher.sv
// Randomised self-checking bench for ifetcher with MEM_LAT=1 and MEM_LAT=3 instances
// against a behavioural fetch model driven from a shared byte-array memory.
module tb_ifetcher;

  localparam int unsigned PC_W   = 25;
  localparam int unsigned MEM_SZ = 4096;

  logic clk = 1'b0;
  logic reset;
  logic load;
  logic [PC_W-1:0] pc_in;

  logic [63:0] mem1, mem3a, mem3b, mem3c;
  logic [47:0] ins1, ins3;
  logic        v1, v3;
  logic [PC_W-1:0] ipc1, ipc3, pco1, pco3;

  logic [7:0] mem [MEM_SZ];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0]  seq     [12] = '{8'h11, 8'hC1, 8'h12, 8'h5F, 8'h21, 8'h41,
                                8'h1E, 8'hC1, 8'h00, 8'h0B, 8'h49, 8'hE1};
  int          exp_ipc [5]  = '{0, 2, 4, 6, 10};
  logic [47:0] exp_ins [5]  = '{48'h11C1_0000_0000, 48'h125F_0000_0000, 48'h2141_0000_0000,
                                48'h1EC1_000B_0000, 48'h49E1_0000_0000};

  always #5 clk = ~clk;

  ifetcher #(.PC_W(PC_W), .RESET_PC(25'h0), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .PC_load_i(load), .PC_i(pc_in), .mem_i(mem1),
    .instruction_o(ins1), .inst_valid_o(v1), .inst_pc_o(ipc1), .PC_o(pco1));

  ifetcher #(.PC_W(PC_W), .RESET_PC(25'h0), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .PC_load_i(load), .PC_i(pc_in), .mem_i(mem3c),
    .instruction_o(ins3), .inst_valid_o(v3), .inst_pc_o(ipc3), .PC_o(pco3));

  function automatic logic [7:0] byte_at(input logic [PC_W-1:0] a);
    return mem[a[11:0]];
  endfunction

  function automatic logic [63:0] window(input logic [PC_W-1:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = byte_at(a + PC_W'(k));
    return w;
  endfunction

  // Registered memories with 1 and 3 cycles of read latency
  always @(posedge clk) begin
    mem1  <= window(pco1);
    mem3a <= window(pco3);
    mem3b <= mem3a;
    mem3c <= mem3b;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: no inst_valid_o within bound (t=%0t)", name, $time);
  endtask

  // Reference decode straight from the byte array
  task automatic ref_fetch(input logic [PC_W-1:0] pc, output logic [47:0] ins,
                           output logic [PC_W-1:0] len);
    logic [15:0] h [3];
    for (int k = 0; k < 3; k++)
      h[k] = {byte_at(pc + PC_W'(2*k)), byte_at(pc + PC_W'(2*k + 1))};
    len = PC_W'(2);
    ins = {h[0], 32'h0};
    if (h[0][10] && h[0][9]) begin
      len = PC_W'(4);
      ins = {h[0], h[1], 16'h0};
    end
`ifdef IFETCH_LONG_INST_EN
    if (h[0][10:5] == 6'b110001 && h[0][4:0] == 5'd0) begin
      len = PC_W'(6);
      ins = {h[0], h[1], h[2]};
    end
`endif
  endtask

  // Model: each instance captures after `lat` edges spent on the current address
  logic [PC_W-1:0] m_pc  [2];
  logic [PC_W-1:0] m_ipc [2];
  logic [47:0]     m_ins [2];
  logic            m_v   [2];
  int              m_age [2];
  int              lat   [2] = '{1, 3};

  initial forever begin
    logic [47:0]     t_ins;
    logic [PC_W-1:0] t_len;
    @(posedge clk or posedge reset);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pc[i] = '0; m_ipc[i] = '0; m_ins[i] = '0; m_v[i] = 1'b0; m_age[i] = 0;
      end else if (load) begin
        m_pc[i] = {pc_in[PC_W-1:1], 1'b0}; m_v[i] = 1'b0; m_age[i] = 0;
      end else if (m_age[i] == lat[i]) begin
        ref_fetch(m_pc[i], t_ins, t_len);
        m_ins[i] = t_ins; m_ipc[i] = m_pc[i]; m_pc[i] = m_pc[i] + t_len;
        m_v[i] = 1'b1; m_age[i] = 0;
      end else begin
        m_age[i]++; m_v[i] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    check("v_lat1",   64'(v1),   64'(m_v[0]));
    check("pc_lat1",  64'(pco1), 64'(m_pc[0]));
    check("ipc_lat1", 64'(ipc1), 64'(m_ipc[0]));
    check("ins_lat1", 64'(ins1), 64'(m_ins[0]));
    check("v_lat3",   64'(v3),   64'(m_v[1]));
    check("pc_lat3",  64'(pco3), 64'(m_pc[1]));
    check("ipc_lat3", 64'(ipc3), 64'(m_ipc[1]));
    check("ins_lat3", 64'(ins3), 64'(m_ins[1]));
  end

  task automatic wait_v1(output int at);
    at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (v1) begin at = cyc; return; end
    end
    fail_now("wait_v1");
  endtask

  task automatic wait_v3(output int at);
    at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (v3) begin at = cyc; return; end
    end
    fail_now("wait_v3");
  endtask

  task automatic redirect(input logic [PC_W-1:0] a);
    @(posedge clk); #1;
    load = 1'b1; pc_in = a;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    int t [5];
    int a3, b3, rel;
    reset = 1'b1; load = 1'b0; pc_in = '0;
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) mem[i] = seq[i];
    mem[12'h100] = 8'h06; mem[12'h101] = 8'h20; mem[12'h102] = 8'h12;
    mem[12'h103] = 8'h34; mem[12'h104] = 8'h56; mem[12'h105] = 8'h78;
    mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'hC1;

    #100;
    @(posedge clk); #1;
    reset = 1'b0;
    rel = cyc;

    // Directed sequence from reset
    for (int i = 0; i < 5; i++) begin
      wait_v1(t[i]);
      check("seq_ipc", 64'(ipc1), 64'(exp_ipc[i]));
      check("seq_ins", 64'(ins1), 64'(exp_ins[i]));
    end
    check("seq_pc_end", 64'(pco1), 64'd12);
    check("first_latency", 64'(t[0] - rel), 64'd2);
    for (int i = 1; i < 5; i++) check("cadence_lat1", 64'(t[i] - t[i-1]), 64'd2);
    wait_v3(a3);
    wait_v3(b3);
    check("cadence_lat3", 64'(b3 - a3), 64'd4);

    // Redirect landing on a capture edge
    wait_v1(a3);
    @(posedge clk); #1;
    load = 1'b1; pc_in = 25'h007;
    @(posedge clk); #1;
    load = 1'b0;
    check("redir_novalid", 64'(v1), 64'd0);
    check("redir_pc", 64'(pco1), 64'h6);
    wait_v1(a3);
    check("redir_ipc", 64'(ipc1), 64'h6);
    check("redir_ins", 64'(ins1), 64'h1EC1_000B_0000);

    // Async reset mid-fetch at PC 4
    redirect(25'h4);
    check("pre_reset_pc", 64'(pco1), 64'h4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_pc", 64'(pco1), 64'd0);
    check("arst_ipc", 64'(ipc1), 64'd0);
    check("arst_ins", 64'(ins1), 64'd0);
    check("arst_valid", 64'(v1), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rel = cyc;
    wait_v1(a3);
    check("restart_ipc", 64'(ipc1), 64'd0);
    check("restart_ins", 64'(ins1), 64'h11C1_0000_0000);
    check("restart_latency", 64'(a3 - rel), 64'd2);

    // Wrap past the top of the address space
    redirect(25'h1FF_FFFE);
    wait_v1(a3);
    check("wrap_ipc", 64'(ipc1), 64'h1FF_FFFE);
    check("wrap_ins", 64'(ins1), 64'h11C1_0000_0000);
    check("wrap_pc", 64'(pco1), 64'd0);

    // MOV imm32 encoding
    redirect(25'h100);
    wait_v1(a3);
`ifdef IFETCH_LONG_INST_EN
    check("mov32_ins", 64'(ins1), 64'h0620_1234_5678);
    check("mov32_pc", 64'(pco1), 64'h106);
`else
    check("mov32_ins", 64'(ins1), 64'h0620_1234_0000);
    check("mov32_pc", 64'(pco1), 64'h104);
`endif

    // Random redirects and occasional async reset pulses
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      load  = ($urandom_range(0, 15) == 0);
      pc_in = PC_W'($urandom);
      if ($urandom_range(0, 7) == 0) pc_in = 25'h1FF_FFF0 | PC_W'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
    end
    @(posedge clk); #1;
    load = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
